player_move_ctrl: RTL

PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

---
 rtl/player_move_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: tile-map player mover; checks the target tile for a wall before committing a step.
//   clk, rst_n             : rising-edge clock, synchronous active-low reset
//   mv_valid/mv_ready/mv_dir : move request handshake (00 up, 01 down, 10 left, 11 right)
//   map_rd_en/_x/_y        : one-cycle tile read strobe and address
//   map_rd_data            : tile id, valid RD_LAT cycles after map_rd_en
//   pos_x/pos_y            : registered player position
//   mv_done/mv_blocked     : move resolved pulse, blocked flag held until next resolution
//   step_cnt               : saturating count of successful moves
module player_move_ctrl #(
  parameter int COORD_W   = 4,
  parameter int MAP_W     = 16,
  parameter int MAP_H     = 16,
  parameter int TILE_W    = 16,
  parameter int WALL_LO   = 1,
  parameter int WALL_HI   = 3,
  parameter int RD_LAT    = 1,
  parameter int EDGE_MODE = 0,
  parameter int START_X   = 0,
  parameter int START_Y   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mv_valid,
  output logic               mv_ready,
  input  logic [1:0]         mv_dir,
  output logic               map_rd_en,
  output logic [COORD_W-1:0] map_rd_x,
  output logic [COORD_W-1:0] map_rd_y,
  input  logic [TILE_W-1:0]  map_rd_data,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               mv_done,
  output logic               mv_blocked,
  output logic [15:0]        step_cnt
);
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAP_H - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] step_q, step_d;
  logic blocked_q, blocked_d;
  logic [COORD_W-1:0] tgt_x, tgt_y;
  logic x_lo, x_hi, y_lo, y_hi, off_map, accept, sample, wall;
  // Edge detection and wrapped target; in clamp mode an edge move is flagged off-map instead.
  always_comb begin
    x_lo    = pos_x_q == '0;
    x_hi    = pos_x_q == X_MAX;
    y_lo    = pos_y_q == '0;
    y_hi    = pos_y_q == Y_MAX;
    tgt_x   = mv_dir == 2'b10 ? (x_lo ? X_MAX : pos_x_q - 1'b1) :
              mv_dir == 2'b11 ? (x_hi ? '0 : pos_x_q + 1'b1) : pos_x_q;
    tgt_y   = mv_dir == 2'b00 ? (y_lo ? Y_MAX : pos_y_q - 1'b1) :
              mv_dir == 2'b01 ? (y_hi ? '0 : pos_y_q + 1'b1) : pos_y_q;
    off_map = (EDGE_MODE == 0) &&
              ((mv_dir == 2'b00 && y_lo) || (mv_dir == 2'b01 && y_hi) ||
               (mv_dir == 2'b10 && x_lo) || (mv_dir == 2'b11 && x_hi));
    accept  = mv_valid && mv_ready;
    sample  = state_q == WAIT && wait_cnt_q == '0;
    wall    = (map_rd_data >= TILE_W'(WALL_LO)) && (map_rd_data <= TILE_W'(WALL_HI));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (accept ? (off_map ? DONE : ISSUE) : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (sample ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    mv_ready  = rst_n && state_q == IDLE;
    map_rd_en = state_q == ISSUE;
    mv_done   = state_q == DONE;
  end
  // The read address register doubles as the pending target for the position update.
  always_comb begin
    rd_x_d     = accept && !off_map ? tgt_x : rd_x_q;
    rd_y_d     = accept && !off_map ? tgt_y : rd_y_q;
    wait_cnt_d = state_q == ISSUE ? CW'(RD_LAT - 1) :
                 state_q == WAIT  ? wait_cnt_q - 1'b1 : wait_cnt_q;
    pos_x_d    = sample && !wall ? rd_x_q : pos_x_q;
    pos_y_d    = sample && !wall ? rd_y_q : pos_y_q;
    step_d     = sample && !wall && step_q != 16'hFFFF ? step_q + 16'd1 : step_q;
    blocked_d  = accept && off_map ? 1'b1 : sample ? wall : blocked_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x_q    <= COORD_W'(START_X);
      pos_y_q    <= COORD_W'(START_Y);
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      wait_cnt_q <= '0;
      step_q     <= '0;
      blocked_q  <= 1'b0;
    end else begin
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      wait_cnt_q <= wait_cnt_d;
      step_q     <= step_d;
      blocked_q  <= blocked_d;
    end
  end
  assign map_rd_x   = rd_x_q;
  assign map_rd_y   = rd_y_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign mv_blocked = blocked_q;
  assign step_cnt   = step_q;
endmodule
